// File: rtl/matrix_pkg.sv
// Shared constants, scan state encoding and frame slicing helper for the
// 5x7 LED matrix scan controller.
package matrix_pkg;

    localparam int MATRIX_COLUMNS = 5;
    localparam int MATRIX_ROWS    = 7;
    localparam int FRAME_BITS     = 35;

    typedef enum logic [1:0] {
        SCAN_OFF   = 2'd0,
        SCAN_BLANK = 2'd1,
        SCAN_DRIVE = 2'd2
    } scan_state_t;

    // Column c of a frame occupies bits [7c+6:7c], bit 7c being row 0.
    function automatic logic [MATRIX_ROWS-1:0] column_slice(
        input logic [FRAME_BITS-1:0] frame,
        input logic [2:0]            col
    );
        column_slice = frame[int'(col)*MATRIX_ROWS +: MATRIX_ROWS];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle enable pulse every DIVIDE cycles;
// clear holds it at zero so a restarted scan always begins a fresh period.
module tick_prescaler #(
    parameter int DIVIDE = 2500
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDE - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || (r_count == LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/matrix_scan_controller.sv
// Time-multiplexed 5x7 LED matrix scanner: blank then drive each column, with a
// shadow frame that is only replaced at frame boundaries or while scanning is off.
module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int DIVIDE      = 2500,
    parameter int BLANK_TICKS = 1,
    parameter int ON_TICKS    = 9
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [FRAME_BITS-1:0]     frame_in,
    input  logic                      update_req,
    output logic                      update_ack,
    output logic [MATRIX_COLUMNS-1:0] matrix_col_n,
    output logic [MATRIX_ROWS-1:0]    matrix_row,
    output logic [2:0]                column_index,
    output logic                      frame_start,
    output scan_state_t               dbg_state
);

    localparam int PHASE_MAX = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
    localparam int PW = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam logic [2:0] LAST_COL = 3'(MATRIX_COLUMNS - 1);

    scan_state_t               r_state, w_state_next;
    logic [PW-1:0]             r_phase, w_phase_next;
    logic [2:0]                r_col, w_col_next;
    logic [MATRIX_COLUMNS-1:0] r_col_n, w_col_n_next;
    logic [MATRIX_ROWS-1:0]    r_row, w_row_next;
    logic [FRAME_BITS-1:0]     r_shadow;
    logic                      r_armed, r_ack, r_frame_start;
    logic                      w_clear, w_tick, w_phase_done, w_wrap, w_accept;

    assign w_clear = ~enable;

    tick_prescaler #(.DIVIDE(DIVIDE)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (w_clear),
        .tick    (w_tick)
    );

    assign w_phase_done = w_tick && (r_phase == ((r_state == SCAN_BLANK) ?
                          PW'(BLANK_TICKS - 1) : PW'(ON_TICKS - 1)));
    assign w_wrap       = enable && (r_state == SCAN_DRIVE) && w_phase_done &&
                          (r_col == LAST_COL);
    // Disabled-path accepts need the FSM to already sit in SCAN_OFF, so a disable
    // coinciding with the wrap edge defers the load to the following edge.
    assign w_accept     = update_req && r_armed &&
                          (w_wrap || ((r_state == SCAN_OFF) && !enable));

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_col_next   = r_col;
        if (!enable) begin
            w_state_next = SCAN_OFF;
            w_phase_next = '0;
            w_col_next   = '0;
        end else begin
            case (r_state)
                SCAN_OFF: begin
                    w_state_next = SCAN_BLANK;
                    w_phase_next = '0;
                    w_col_next   = '0;
                end
                SCAN_BLANK: begin
                    if (w_phase_done) begin
                        w_state_next = SCAN_DRIVE;
                        w_phase_next = '0;
                    end else if (w_tick) begin
                        w_phase_next = r_phase + PW'(1);
                    end
                end
                SCAN_DRIVE: begin
                    if (w_phase_done) begin
                        w_state_next = SCAN_BLANK;
                        w_phase_next = '0;
                        w_col_next   = (r_col == LAST_COL) ? 3'd0 : r_col + 3'd1;
                    end else if (w_tick) begin
                        w_phase_next = r_phase + PW'(1);
                    end
                end
                default: begin
                    w_state_next = SCAN_OFF;
                    w_phase_next = '0;
                    w_col_next   = '0;
                end
            endcase
        end
    end

    // Pin values are decoded from the next state so they switch on the same edge.
    always_comb begin
        w_col_n_next = '1;
        w_row_next   = '0;
        if (w_state_next == SCAN_DRIVE) begin
            w_col_n_next = ~(MATRIX_COLUMNS'(1) << w_col_next);
            w_row_next   = column_slice(r_shadow, w_col_next);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SCAN_BLANK;
            r_phase <= '0;
            r_col   <= '0;
            r_col_n <= '1;
            r_row   <= '0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_col   <= w_col_next;
            r_col_n <= w_col_n_next;
            r_row   <= w_row_next;
        end
    end

    // A request must be seen low once after each ack before it can be accepted again.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow      <= '0;
            r_armed       <= 1'b0;
            r_ack         <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_ack         <= w_accept;
            r_frame_start <= w_wrap;
            if (w_accept) begin
                r_shadow <= frame_in;
                r_armed  <= 1'b0;
            end else if (!update_req) begin
                r_armed  <= 1'b1;
            end
        end
    end

    assign update_ack   = r_ack;
    assign frame_start  = r_frame_start;
    assign matrix_col_n = r_col_n;
    assign matrix_row   = r_row;
    assign column_index = r_col;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: a timeline-position model of the scan and the
// frame handshake, compared against the pins every cycle by each scenario task.
module tb_matrix_scan_controller;
    import matrix_pkg::*;

    localparam int DIVIDE      = 2;
    localparam int BLANK_TICKS = 1;
    localparam int ON_TICKS    = 3;
    localparam int SLOT        = (BLANK_TICKS + ON_TICKS) * DIVIDE;
    localparam int FRAME       = MATRIX_COLUMNS * SLOT;
    localparam int BLANK_CYC   = BLANK_TICKS * DIVIDE;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b0;
    logic        update_req = 1'b0;
    logic [34:0] frame_in = '0;
    logic        update_ack, frame_start;
    logic [4:0]  matrix_col_n;
    logic [6:0]  matrix_row;
    logic [2:0]  column_index;
    scan_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: m_pos is the number of cycles into the scan timeline since the scan
    // (re)started; the display content is a pure function of it and the shadow frame.
    logic        m_on, m_armed, m_ack, m_fs;
    int          m_pos;
    logic [34:0] m_shadow;
    logic        n_on, n_wrap, n_acc;
    int          n_pos;
    logic [18:0] obs;

    matrix_scan_controller #(
        .DIVIDE      (DIVIDE),
        .BLANK_TICKS (BLANK_TICKS),
        .ON_TICKS    (ON_TICKS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .frame_in     (frame_in),
        .update_req   (update_req),
        .update_ack   (update_ack),
        .matrix_col_n (matrix_col_n),
        .matrix_row   (matrix_row),
        .column_index (column_index),
        .frame_start  (frame_start),
        .dbg_state    (dbg_state)
    );

    always #5 clock = ~clock;

    assign obs = {matrix_col_n, matrix_row, column_index, update_ack, frame_start, dbg_state};

    always_comb begin
        n_on   = m_on;
        n_pos  = m_pos;
        n_wrap = 1'b0;
        n_acc  = 1'b0;
        if (!enable) begin
            n_acc = update_req && m_armed && !m_on;
            n_on  = 1'b0;
            n_pos = 0;
        end else if (!m_on) begin
            // The prescaler starts counting on the restart edge itself.
            n_on  = 1'b1;
            n_pos = 1;
        end else begin
            n_pos  = m_pos + 1;
            n_wrap = (n_pos % FRAME) == 0;
            n_acc  = update_req && m_armed && n_wrap;
        end
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_on     <= 1'b1;
            m_pos    <= 0;
            m_shadow <= '0;
            m_armed  <= 1'b0;
            m_ack    <= 1'b0;
            m_fs     <= 1'b0;
            cyc      <= 0;
        end else begin
            m_on  <= n_on;
            m_pos <= n_pos;
            m_ack <= n_acc;
            m_fs  <= n_wrap;
            cyc   <= cyc + 1;
            if (n_acc) m_shadow <= frame_in;
            if (n_acc) m_armed <= 1'b0;
            else if (!update_req) m_armed <= 1'b1;
        end
    end

    function automatic logic [18:0] exp_vec();
        logic [4:0]  cn;
        logic [6:0]  rw;
        logic [2:0]  ci;
        scan_state_t st;
        cn = '1;
        rw = '0;
        ci = '0;
        st = SCAN_OFF;
        if (m_on) begin
            ci = 3'((m_pos / SLOT) % MATRIX_COLUMNS);
            st = SCAN_BLANK;
            if ((m_pos % SLOT) >= BLANK_CYC) begin
                st = SCAN_DRIVE;
                cn = ~(5'b00001 << ci);
                rw = m_shadow[int'(ci)*7 +: 7];
            end
        end
        return {cn, rw, ci, m_ack, m_fs, st};
    endfunction

    function automatic logic [34:0] rand_frame();
        return 35'({$urandom_range(0, 7), $urandom()});
    endfunction

    task automatic test_reset();
        logic [18:0] dark;
        dark = {5'b11111, 7'h00, 3'd0, 1'b0, 1'b0, SCAN_BLANK};
        enable = 1'b1;
        update_req = 1'b0;
        frame_in = '0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== dark) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs, dark);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_cycle0: got %h expected %h", obs, exp_vec());
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reset_scan cyc %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if (i == 1 || i == 2 || i == 7 || i == 8) begin
                checks++;
                if ((i == 1 && matrix_col_n !== 5'b11111) ||
                    (i == 2 && (matrix_col_n !== 5'b11110 || matrix_row !== 7'h00)) ||
                    (i == 7 && matrix_col_n !== 5'b11110) ||
                    (i == 8 && (matrix_col_n !== 5'b11111 || column_index !== 3'd1))) begin
                    errors++;
                    $display("FAIL first_drive cyc %0d: got col_n %b col %0d", i, matrix_col_n, column_index);
                end
            end
        end
    endtask

    task automatic test_frame_update();
        int ack_cyc;
        logic fs_at_ack;
        ack_cyc = -1;
        fs_at_ack = 1'b0;
        frame_in = 35'h4_0000_0001;
        update_req = 1'b1;
        for (int i = 0; i < 60 && cyc < 48; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL update_scan cyc %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if (update_ack === 1'b1) begin
                ack_cyc = cyc;
                fs_at_ack = frame_start;
            end
            if (cyc >= FRAME + BLANK_CYC && cyc < FRAME + SLOT) begin
                checks++;
                if (matrix_col_n !== 5'b11110 || matrix_row !== 7'h01) begin
                    errors++;
                    $display("FAIL new_frame_col0 cyc %0d: got %b/%h expected 11110/01", cyc, matrix_col_n, matrix_row);
                end
            end
        end
        checks++;
        if (ack_cyc != FRAME || fs_at_ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_at_wrap: got cyc %0d fs %b expected cyc %0d fs 1", ack_cyc, fs_at_ack, FRAME);
        end
    endtask

    task automatic test_hold_req();
        int acks;
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL hold_scan cyc %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if (update_ack === 1'b1) acks++;
            if ((m_pos % FRAME) >= 4 * SLOT + BLANK_CYC) begin
                checks++;
                if (matrix_col_n !== 5'b01111 || matrix_row !== 7'h40) begin
                    errors++;
                    $display("FAIL new_frame_col4 cyc %0d: got %b/%h expected 01111/40", cyc, matrix_col_n, matrix_row);
                end
            end
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL held_req_reack: got %0d extra acks expected 0", acks);
        end
        update_req = 1'b0;
    endtask

    task automatic test_disable();
        logic [18:0] off_vec;
        logic [34:0] f;
        off_vec = {5'b11111, 7'h00, 3'd0, 1'b0, 1'b0, SCAN_OFF};
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL pre_disable cyc %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if ((m_pos % FRAME) == 2 * SLOT + BLANK_CYC + 1) break;
        end
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== off_vec || obs !== exp_vec()) begin
            errors++;
            $display("FAIL disable_dark: got %h expected %h", obs, off_vec);
        end
        f = rand_frame();
        frame_in = f;
        update_req = 1'b1;
        @(negedge clock);
        checks++;
        if (update_ack !== 1'b1 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL off_ack_latency: got ack %b vec %h expected ack 1 vec %h", update_ack, obs, exp_vec());
        end
        update_req = 1'b0;
        repeat (3) @(negedge clock);
        enable = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_vec() || frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reenable cyc %0d: got %h expected %h", i, obs, exp_vec());
            end
            if (i == 2) begin
                checks++;
                if (matrix_col_n !== 5'b11110 || matrix_row !== f[6:0]) begin
                    errors++;
                    $display("FAIL reenable_drive: got %b/%h expected 11110/%h", matrix_col_n, matrix_row, f[6:0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] dark;
        int acks;
        dark = {5'b11111, 7'h00, 3'd0, 1'b0, 1'b0, SCAN_BLANK};
        acks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL pre_reset cyc %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if ((m_pos % FRAME) == SLOT + BLANK_CYC + 1) break;
        end
        frame_in = rand_frame();
        update_req = 1'b1;
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs !== dark) begin
            errors++;
            $display("FAIL reset_mid_dark: got %h expected %h", obs, dark);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < FRAME + SLOT; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_vec() || matrix_row !== 7'h00) begin
                errors++;
                $display("FAIL after_reset cyc %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if (update_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL dropped_req_ack: got %0d acks expected 0", acks);
        end
        update_req = 1'b0;
    endtask

    task automatic test_disable_on_wrap();
        int acks;
        acks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL pre_wrap cyc %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if (m_on && (m_pos % FRAME) == FRAME - 1) break;
        end
        frame_in = rand_frame();
        update_req = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        checks++;
        if (dbg_state !== SCAN_OFF || update_ack !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL wrap_disable_wins: got state %0d ack %b fs %b expected 0 0 0", dbg_state, update_ack, frame_start);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_off cyc %0d: got %h expected %h", i, obs, exp_vec());
            end
            if (update_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 1) begin
            errors++;
            $display("FAIL wrap_off_single_ack: got %0d acks expected 1", acks);
        end
        update_req = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_random();
        logic acked;
        acked = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h expected %h", cyc, obs, exp_vec());
            end
            if (m_ack) acked = 1'b1;
            if (update_req) begin
                if (acked && $urandom_range(0, 3) == 0) begin
                    update_req = 1'b0;
                    acked = 1'b0;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                frame_in = rand_frame();
                update_req = 1'b1;
            end
            if (enable) begin
                if ($urandom_range(0, 99) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                enable = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_update();
        test_hold_req();
        test_disable();
        test_reset_mid();
        test_disable_on_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
